// File: rtl/ct_spsram_512x7_ctrl.sv
// Front-end for the 512x7 single-port SRAM: clears the array to INIT_VAL, then serves one read/write per cycle.
// Latency: write lands at the accepting edge; read data flagged 1 cycle after accept (2 with RD_FLOP=1).
// Backpressure: req_rdy low outside RUN and in any cycle that init_start is asserted.
module ct_spsram_512x7_ctrl #(
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DATA_WIDTH = 7,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
    parameter int                    RD_FLOP    = 0,
    parameter int                    AUTO_INIT  = 1
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_start,
    input  logic                  req_vld,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_bwe,
    output logic                  req_rdy,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  init_busy,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    acc;
    logic                    rd_acc;
    logic                    rd_vld_s1;

    assign req_rdy   = (state == RUN) && !init_start;
    assign acc       = req_rdy && req_vld;
    assign rd_acc    = acc && !req_wr;
    assign init_busy = (state == INIT);

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state     <= IDLE;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    state <= (init_start || (AUTO_INIT != 0)) ? INIT : RUN;
                end
                INIT: begin
                    if (init_start) begin
                        cnt       <= '0;
                        init_done <= 1'b0;
                    end else if (cnt == LAST_IDX) begin
                        cnt       <= '0;
                        state     <= RUN;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (init_start) begin
                        state     <= INIT;
                        cnt       <= '0;
                        init_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM pins are driven combinationally so the macro samples them on the accepting edge.
    always_comb begin
        sram_a    = '0;
        sram_cen  = 1'b1;
        sram_d    = '0;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        if (state == INIT) begin
            sram_a    = cnt;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_d    = INIT_VAL;
        end else if (acc) begin
            sram_a   = req_addr;
            sram_cen = 1'b0;
            if (req_wr) begin
                sram_d    = req_wdata;
                sram_wen  = ~req_bwe;
                sram_gwen = (req_bwe == '0);
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_vld_s1 <= 1'b0;
        end else begin
            rd_vld_s1 <= rd_acc;
        end
    end

    generate
        if (RD_FLOP == 0) begin : g_rd_direct
            assign rd_vld  = rd_vld_s1;
            assign rd_data = rd_vld_s1 ? sram_q : '0;
        end else begin : g_rd_flop
            logic                  rd_vld_s2;
            logic [DATA_WIDTH-1:0] rd_data_q;
            always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
                if (!cpurst_b) begin
                    rd_vld_s2 <= 1'b0;
                    rd_data_q <= '0;
                end else begin
                    rd_vld_s2 <= rd_vld_s1;
                    rd_data_q <= rd_vld_s1 ? sram_q : '0;
                end
            end
            assign rd_vld  = rd_vld_s2;
            assign rd_data = rd_data_q;
        end
    endgenerate

endmodule
